fetch_unit_ras: RTL

//  Parametrised successor to the CPU's PC/IR front end. Owns PC, instruction register and a

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/ras_stack.sv | 74 +++++++
 rtl/fetch_unit_ras.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   mem_cmd_e     : memory command codes driven on mem_cmd.
//   pc_sel_e      : PC update selectors carried on pc_sel (6 and 7 are reserved no-ops).
//   fetch_state_e : states of the instruction-fetch controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MREAD  = 2'b01,
    MWRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [2:0] {
    PC_RSTV = 3'd0,
    PC_ABS  = 3'd1,
    PC_REL  = 3'd2,
    PC_INC  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_sel_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_data : push i_data; when full the oldest entry is overwritten
//   i_pop          : discard the top entry; popping an empty stack leaves it empty
//   o_top          : current top entry (meaningful only when !o_empty)
//   o_empty/o_full : occupancy flags
//   o_ovf/o_unf    : sticky overflow / underflow flags, cleared by reset only
// i_push and i_pop are never asserted together by the parent.
module ras_stack
  import cpu_pkg::*;
#(
  parameter int AW        = 9,
  parameter int RAS_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [AW-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_sp;      // next slot to write; top lives at r_sp-1
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic          r_unf;
  logic [PW-1:0] w_top_idx;
  logic          w_empty;
  logic          w_full;

  assign w_top_idx = r_sp - PW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (PW+1)'(RAS_DEPTH));

  assign o_top   = r_mem[w_top_idx];
  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

  // NOTE: the storage array is cleared on reset too, so o_top never shows
  // stale data from before reset; at this depth the cost is negligible.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_push) begin
      // When full, r_sp already points at the oldest entry, so writing there
      // drops it and the count saturates.
      r_mem[r_sp] <= i_data;
      r_sp        <= r_sp + PW'(1);
      if (w_full) r_ovf   <= 1'b1;
      else        r_count <= r_count + (PW+1)'(1);
    end else if (i_pop) begin
      if (w_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_sp    <= w_top_idx;
        r_count <= r_count - (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit_ras.sv
// PC / instruction-register front end with return-address stack and a
// wait-state memory read handshake with timeout.
//   clk, reset    : clock, synchronous active-low reset
//   halt          : freezes all state; no memory command while high
//   pc_load       : update PC according to pc_sel (only when idle)
//   pc_sel        : RSTV, ABS, REL, INC, CALL, RET (6-7 no-op)
//   abs_target    : target for ABS and CALL
//   rel_offset    : two's-complement offset for REL
//   fetch_req     : start a fetch at PC (the updated PC if pc_load is also high)
//   mem_cmd       : NONE / READ
//   mem_addr      : fetch address, held for the whole fetch
//   mem_rdata     : read data, taken when mem_ready is high
//   mem_ready     : read data valid
//   ir, ir_valid  : instruction register and its one-cycle update pulse
//   pc            : program counter
//   busy          : a fetch is in progress
//   fetch_err     : sticky, a fetch timed out
//   ras_ovf       : sticky, CALL pushed onto a full stack
//   ras_unf       : sticky, RET popped an empty stack
module fetch_unit_ras
  import cpu_pkg::*;
#(
  parameter int            AW        = 9,
  parameter int            IW        = 16,
  parameter int            RAS_DEPTH = 4,
  parameter int            MAX_WAIT  = 15,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          pc_load,
  input  logic [2:0]    pc_sel,
  input  logic [AW-1:0] abs_target,
  input  logic [AW-1:0] rel_offset,
  input  logic          fetch_req,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  input  logic [IW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          fetch_err,
  output logic          ras_ovf,
  output logic          ras_unf
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  fetch_state_e  r_state;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_ir;
  logic          r_ir_valid;
  logic [AW-1:0] r_mem_addr;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic          r_fetch_err;

  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_next;
  logic          w_do_load;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_ras_top;
  logic          w_ras_empty;
  logic          w_unused_ras_full;
  logic          w_ras_ovf;
  logic          w_ras_unf;

  // PC requests are honoured only when idle and not frozen.
  assign w_do_load = pc_load && !halt && (r_state == S_IDLE);
  assign w_push    = w_do_load && (pc_sel == PC_CALL);
  assign w_pop     = w_do_load && (pc_sel == PC_RET);
  assign w_pc_inc  = r_pc + AW'(1);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which keeps this purely combinational.
  always_comb begin
    w_pc_next = r_pc;
    case (pc_sel)
      PC_RSTV: w_pc_next = RESET_VEC;
      PC_ABS:  w_pc_next = abs_target;
      PC_REL:  w_pc_next = r_pc + rel_offset;
      PC_INC:  w_pc_next = w_pc_inc;
      PC_CALL: w_pc_next = abs_target;
      PC_RET:  w_pc_next = w_ras_empty ? RESET_VEC : w_ras_top;
      default: w_pc_next = r_pc;
    endcase
  end

  ras_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_unused_ras_full),
    .o_ovf   (w_ras_ovf),
    .o_unf   (w_ras_unf)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_VEC;
      r_ir        <= '0;
      r_ir_valid  <= 1'b0;
      r_mem_addr  <= '0;
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      if (!halt) begin
        case (r_state)
          S_IDLE: begin
            if (pc_load) r_pc <= w_pc_next;
            if (fetch_req) begin
              r_state    <= S_FETCH;
              r_wait_cnt <= '0;
              // A simultaneous PC update wins: fetch from the new PC.
              r_mem_addr <= pc_load ? w_pc_next : r_pc;
            end
          end
          S_FETCH: begin
            if (mem_ready) begin
              r_ir       <= mem_rdata;
              r_ir_valid <= 1'b1;
              r_state    <= S_IDLE;
            end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
              r_fetch_err <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_cmd   = ((r_state == S_FETCH) && !halt) ? MREAD : MNONE;
  assign mem_addr  = r_mem_addr;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign pc        = r_pc;
  assign busy      = (r_state == S_FETCH);
  assign fetch_err = r_fetch_err;
  assign ras_ovf   = w_ras_ovf;
  assign ras_unf   = w_ras_unf;

endmodule
